// File: rtl/core_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : core_run_controller
// Purpose  : Sequences a core through reset and run, and ends the run on a
//            tohost store, a PC stall (CORE_RUN_CONTROLLER_STALL_DETECT_EN)
//            or a cycle-budget timeout.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_controller #(
    parameter int               XLEN        = 32,
    parameter int               RST_CYCLES  = 2,
    parameter int               MAX_CYCLES  = 1000,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = XLEN'(32'h0000_0100),
    parameter int               STALL_LIMIT = 4,
    parameter int               CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [XLEN-1:0]  exit_code,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int               C_RST_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [C_RST_W-1:0] C_RST_LAST = C_RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W:0]   C_MAX_CYCLES = (CNT_W+1)'(MAX_CYCLES);
    localparam logic [1:0]       C_ST_NONE    = 2'b00;
    localparam logic [1:0]       C_ST_PASS    = 2'b01;
    localparam logic [1:0]       C_ST_FAIL    = 2'b10;
    localparam logic [1:0]       C_ST_TIMEOUT = 2'b11;

    state_e              state_q, state_d;
    logic [C_RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [1:0]          status_q, status_d;
    logic [XLEN-1:0]     exit_code_q, exit_code_d;
    logic                core_rst_q, core_rst_d;
    logic                running_q, running_d;
    logic                done_q, done_d;

    logic                w_enter_reset;
    logic                w_stall_hit;
    logic                w_tohost;
    logic                w_timeout;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_enter_reset = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign w_tohost      = mem_we && (mem_addr == TOHOST_ADDR);
    assign w_cnt_inc     = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;
    assign w_timeout     = ({1'b0, w_cnt_inc} >= C_MAX_CYCLES);

`ifdef CORE_RUN_CONTROLLER_STALL_DETECT_EN
    localparam int                     C_STALL_W   = $clog2(STALL_LIMIT);
    localparam logic [C_STALL_W-1:0]   C_STALL_PRE = C_STALL_W'(STALL_LIMIT - 2);

    logic [C_STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0]      prev_pc_q, prev_pc_d;
    logic                 pc_valid_q, pc_valid_d;

    // pc_valid keeps the first RUN sample from being compared against stale data
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        prev_pc_d   = prev_pc_q;
        pc_valid_d  = pc_valid_q;
        w_stall_hit = 1'b0;
        if (state_q == ST_RUN) begin
            prev_pc_d  = pc;
            pc_valid_d = 1'b1;
            if (pc_valid_q && (pc == prev_pc_q)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
                w_stall_hit = (stall_cnt_q == C_STALL_PRE);
            end else begin
                stall_cnt_d = '0;
            end
        end else if (w_enter_reset) begin
            stall_cnt_d = '0;
            pc_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            prev_pc_q   <= '0;
            pc_valid_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            prev_pc_q   <= prev_pc_d;
            pc_valid_q  <= pc_valid_d;
        end
    end
`else
    logic w_pc_unused;
    assign w_pc_unused = ^pc;
    assign w_stall_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rst_cnt_d     = rst_cnt_q;
        cycle_count_d = cycle_count_q;
        status_d      = status_q;
        exit_code_d   = exit_code_q;
        core_rst_d    = core_rst_q;
        running_d     = running_q;
        done_d        = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_enter_reset) begin
                    state_d       = ST_RESET;
                    rst_cnt_d     = '0;
                    cycle_count_d = '0;
                    status_d      = C_ST_NONE;
                    exit_code_d   = '0;
                    core_rst_d    = 1'b0;
                    running_d     = 1'b0;
                    done_d        = 1'b0;
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == C_RST_LAST) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b1;
                    running_d  = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                cycle_count_d = w_cnt_inc;
                if (w_tohost || w_stall_hit || w_timeout) begin
                    state_d    = ST_DONE;
                    core_rst_d = 1'b0;
                    running_d  = 1'b0;
                    done_d     = 1'b1;
                end
                // Termination sources are ranked tohost > stall > timeout
                if (w_tohost) begin
                    if (mem_wdata == XLEN'(1)) begin
                        status_d    = C_ST_PASS;
                        exit_code_d = '0;
                    end else begin
                        status_d    = C_ST_FAIL;
                        exit_code_d = {1'b0, mem_wdata[XLEN-1:1]};
                    end
                end else if (w_stall_hit) begin
                    status_d = C_ST_PASS;
                end else if (w_timeout) begin
                    status_d = C_ST_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rst_cnt_q     <= '0;
            cycle_count_q <= '0;
            status_q      <= C_ST_NONE;
            exit_code_q   <= '0;
            core_rst_q    <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            cycle_count_q <= cycle_count_d;
            status_q      <= status_d;
            exit_code_q   <= exit_code_d;
            core_rst_q    <= core_rst_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign core_rst    = core_rst_q;
    assign running     = running_q;
    assign done        = done_q;
    assign status      = status_q;
    assign exit_code   = exit_code_q;
    assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 Parameter XLEN, 32, width of PC, address and data buses.
REQ-002 Parameter RST_CYCLES, 2, core reset hold length in cycles (>=1).
REQ-003 Parameter MAX_CYCLES, 1000, run-cycle budget before timeout (>=1).
REQ-004 Parameter TOHOST_ADDR, 32'h0000_0100, store address that terminates a test.
REQ-005 Parameter STALL_LIMIT, 4, consecutive unchanged-PC cycles that mean halt (>=2).
REQ-006 Parameter CNT_W, 32, cycle counter width.
REQ-007 clk  input  1  single clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  level-sampled request to begin a run.
REQ-010 pc  input  XLEN  core program counter, sampled every RUN cycle.
REQ-011 mem_we  input  1  core data-memory write strobe.
REQ-012 mem_addr  input  XLEN  core data-memory write address.
REQ-013 mem_wdata  input  XLEN  core data-memory write data.
REQ-014 core_rst  output  1  reset driven to the core, active-low (0 = core held in reset).
REQ-015 running  output  1  high while in RUN.
REQ-016 done  output  1  high while in DONE.
REQ-017 status  output  2  00 none, 01 pass, 10 fail, 11 timeout.
REQ-018 exit_code  output  XLEN  fail code (mem_wdata >> 1), else 0.
REQ-019 cycle_count  output  CNT_W  RUN cycles elapsed in current/last run.

Function
REQ-020 FSM states IDLE, RESET, RUN, DONE; all outputs registered.
REQ-021 IDLE: start=1 -> RESET next edge; else stay.
REQ-022 Entering RESET: cycle_count, status, exit_code, stall counter cleared; core_rst=0.
REQ-023 RESET lasts exactly RST_CYCLES cycles, then RUN; core_rst=1 from first RUN cycle.
REQ-024 RUN: cycle_count +1 per cycle, saturating at all-ones.
REQ-025 RUN: mem_we=1 and mem_addr==TOHOST_ADDR -> DONE; mem_wdata==1 gives status 01, exit_code 0; any other value gives status 10, exit_code mem_wdata>>1.
REQ-026 RUN: completing the MAX_CYCLES-th run cycle with no terminating event -> DONE, status 11.
REQ-027 Priority when coincident in one cycle: tohost write > stall halt > timeout.
REQ-028 DONE: core_rst=0 (core frozen), outputs held; start=1 -> RESET (restart); else stay.
REQ-029 start in RESET or RUN ignored.
REQ-030 mem_we with any other address has no effect.

Reset
REQ-031 rst=1 at any edge forces IDLE, core_rst=0, running=0, done=0, status=00, exit_code=0, cycle_count=0, stall counter=0, regardless of state (mid-run included).
REQ-032 rst has priority over start and all RUN events in the same cycle.

Configuration
REQ-033 Macro CORE_RUN_CONTROLLER_STALL_DETECT_EN defined: in RUN, pc equal to previous-cycle pc increments stall counter, else clears it; counter reaching STALL_LIMIT-1 equal compares (STALL_LIMIT identical samples) -> DONE, status 01; first RUN cycle has no previous sample and never counts.
REQ-034 Macro undefined: no stall logic or PC register synthesised; pc input unused; runs end only by tohost or timeout.

Verification
REQ-035 rst, start pulse, RST_CYCLES=2 -> core_rst low 2 cycles after start edge, then high, running=1.
REQ-036 tohost write data 1 at run cycle 10 -> next edge done=1, status=01, cycle_count=10, core_rst=0.
REQ-037 tohost write data 7 -> status=10, exit_code=3; write data 1 to TOHOST_ADDR+4 -> ignored.
REQ-038 MAX_CYCLES=20, no writes, pc incrementing -> done after 20 run cycles, status=11, cycle_count=20.
REQ-039 With STALL_DETECT_EN, pc held constant from cycle 5, STALL_LIMIT=4 -> status=01 after 4th identical sample; same cycle tohost data 5 -> status=10 wins.
REQ-040 rst asserted mid-RUN -> next edge IDLE, all outputs reset values; start in DONE -> fresh run with cycle_count restarting at 0.
